lamp_shifter: RTL and testbench
===============================

LAMP_SHIFTER -- requirements
Module: lamp_shifter

Interface
REQ-001 Parameter MX_LP, default 16, is the lamp vector width.
REQ-002 Parameter CLK_DIV, default 2, is the sclk half-period in clk cycles; legal values are 1 or greater.
REQ-003 Clocking SHALL be: one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  system clock; all state changes on rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 a_lamp  input  MX_LP  lamp vector from bound flasher, sampled every clk.
REQ-007 refresh  input  1  one-cycle request to resend current a_lamp even if unchanged.
REQ-008 sclk  output  1  serial clock to external LED shift-register driver.
REQ-009 sdata  output  1  serial data, MSB (lamp[MX_LP-1]) first.
REQ-010 latch  output  1  storage-register strobe to driver.
REQ-011 busy  output  1  high while a frame is in progress.

Function
REQ-012 The state machine SHALL have states IDLE, SHIFT and LATCH, all outputs registered.
REQ-013 Block SHALL hold last_sent (MX_LP bits, the last latched frame) and a pending flag.
REQ-014 In IDLE, start a frame if a_lamp != last_sent, or refresh=1, or pending=1; otherwise remain.
REQ-015 On start: capture a_lamp into the shift register, clear pending, state->SHIFT, busy=1, sclk=0, sdata=captured MSB, all in the same edge.
REQ-016 SHIFT, per bit: sclk low CLK_DIV cycles then high CLK_DIV cycles; sdata stable throughout the bit and changes only at the high->low transition.
REQ-017 After MX_LP bits: state->LATCH, sclk=0, sdata=0, latch=1 for CLK_DIV cycles; on exit last_sent<=captured value, latch=0, busy=0, state->IDLE.
REQ-018 busy SHALL be high for exactly (2*MX_LP+1)*CLK_DIV cycles per frame (66 at defaults).
REQ-019 Frames are never aborted; a_lamp changes during SHIFT/LATCH are ignored in-frame and caught by the IDLE comparison afterwards (newest value wins, intermediates dropped).
REQ-020 refresh during SHIFT/LATCH sets pending; multiple requests collapse to one extra frame.
REQ-021 Back-to-back frames: a new frame may start on the first IDLE cycle, giving one idle cycle (busy=0) between frames.
REQ-022 Bit and phase counters SHALL be sized for MX_LP and CLK_DIV with no wrap inside a frame.

Reset
REQ-023 While rst=1 at a rising edge: state=IDLE; sclk, sdata, latch and busy = 0; last_sent=0; pending=0; counters=0.
REQ-024 Reset mid-frame abandons it with no latch pulse; after release a nonzero a_lamp retransmits from MSB.
REQ-025 rst SHALL take priority over every other input.

Structure
REQ-026 Shared package lamp_pkg SHALL hold the state enum (IDLE, SHIFT, LATCH) and default MX_LP=16.
REQ-027 Sub-module phase_timer SHALL count CLK_DIV cycles and emit a one-cycle phase_done; the FSM, shift register and last_sent stay in lamp_shifter.

Verification
REQ-028 rst held 3 cycles with a_lamp=0, then released: busy, sclk, sdata and latch stay 0 for 100 cycles.
REQ-029 a_lamp=16'h8001 in IDLE: busy high 66 cycles; sdata at the 16 sclk rises = 1,0x14,1; latch high 2 cycles after the last sclk fall, then busy=0.
REQ-030 a_lamp 0x0001->0x0003->0x0007 within one frame: exactly two frames total, the second carrying 0x0007.
REQ-031 a_lamp=16'hFFFF already sent, refresh pulsed once in IDLE: one frame of 0xFFFF; refresh pulsed 3 times during busy: exactly one further frame.
REQ-032 rst asserted during SHIFT bit 8 of 0x00FF: next edge all outputs 0 with no latch pulse; after release, a full 0x00FF frame follows.
REQ-033 CLK_DIV=1, a_lamp=16'hA5A5: busy 33 cycles, sclk period 2 clk, shifted bits equal 1010010110100101.

Source files
------------

// File: rtl/lamp_shifter_pkg.sv
// Shared types and defaults for the lamp shift-out block.
package lamp_pkg;

  localparam int unsigned MX_LP_DEF   = 16;
  localparam int unsigned CLK_DIV_DEF = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } lamp_state_e;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lamp_shifter_phase_timer.sv
// Phase timer: counts CLK_DIV enabled cycles and flags the last one of each phase.
module phase_timer
  import lamp_pkg::*;
#(
  parameter int unsigned CLK_DIV = CLK_DIV_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  output logic o_phase_done_c
);

  localparam int unsigned CW = cnt_width(CLK_DIV);

  logic [CW-1:0] r_cnt;

  assign o_phase_done_c = i_en && (r_cnt == CW'(CLK_DIV - 1));

  // Count while enabled; restart at each phase boundary and whenever disabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (!i_en || o_phase_done_c) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/lamp_shifter.sv
// Serialises the lamp vector to an external LED shift-register driver,
// resending only when the vector changes or a refresh is requested.
module lamp_shifter
  import lamp_pkg::*;
#(
  parameter int unsigned MX_LP   = MX_LP_DEF,
  parameter int unsigned CLK_DIV = CLK_DIV_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [MX_LP-1:0] a_lamp,
  input  logic             refresh,
  output logic             sclk,
  output logic             sdata,
  output logic             latch,
  output logic             busy
);

  localparam int unsigned BW = cnt_width(MX_LP);

  lamp_state_e      r_state;
  lamp_state_e      w_state_nxt;
  logic [MX_LP-1:0] r_shreg;
  logic [MX_LP-1:0] w_shreg_nxt;
  logic [MX_LP-1:0] w_shreg_shl;
  logic [MX_LP-1:0] r_frame;
  logic [MX_LP-1:0] w_frame_nxt;
  logic [MX_LP-1:0] r_last_sent;
  logic [MX_LP-1:0] w_last_sent_nxt;
  logic             r_pending;
  logic             w_pending_nxt;
  logic [BW-1:0]    r_bit_cnt;
  logic [BW-1:0]    w_bit_cnt_nxt;
  logic             r_sclk;
  logic             w_sclk_nxt;
  logic             r_sdata;
  logic             w_sdata_nxt;
  logic             r_latch;
  logic             w_latch_nxt;
  logic             r_busy;
  logic             w_busy_nxt;
  logic             w_start;
  logic             w_phase_done;
  logic             w_timer_en;

  assign w_timer_en  = (r_state != IDLE);
  assign w_start     = (a_lamp != r_last_sent) || refresh || r_pending;
  assign w_shreg_shl = {r_shreg[MX_LP-2:0], 1'b0};

  phase_timer #(
    .CLK_DIV(CLK_DIV)
  ) u_phase_timer (
    .clk            (clk),
    .rst            (rst),
    .i_en           (w_timer_en),
    .o_phase_done_c (w_phase_done)
  );

  // State and output registers; reset abandons any frame without a latch pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_shreg     <= '0;
      r_frame     <= '0;
      r_last_sent <= '0;
      r_pending   <= 1'b0;
      r_bit_cnt   <= '0;
      r_sclk      <= 1'b0;
      r_sdata     <= 1'b0;
      r_latch     <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_shreg     <= w_shreg_nxt;
      r_frame     <= w_frame_nxt;
      r_last_sent <= w_last_sent_nxt;
      r_pending   <= w_pending_nxt;
      r_bit_cnt   <= w_bit_cnt_nxt;
      r_sclk      <= w_sclk_nxt;
      r_sdata     <= w_sdata_nxt;
      r_latch     <= w_latch_nxt;
      r_busy      <= w_busy_nxt;
    end
  end

  // Next-state and next-output logic: frame start, per-bit sclk phases, latch strobe.
  always_comb begin
    w_state_nxt     = r_state;
    w_shreg_nxt     = r_shreg;
    w_frame_nxt     = r_frame;
    w_last_sent_nxt = r_last_sent;
    w_pending_nxt   = r_pending;
    w_bit_cnt_nxt   = r_bit_cnt;
    w_sclk_nxt      = r_sclk;
    w_sdata_nxt     = r_sdata;
    w_latch_nxt     = r_latch;
    w_busy_nxt      = r_busy;

    unique case (r_state)
      IDLE: begin
        if (w_start) begin
          w_state_nxt   = SHIFT;
          w_shreg_nxt   = a_lamp;
          w_frame_nxt   = a_lamp;
          w_pending_nxt = 1'b0;
          w_bit_cnt_nxt = '0;
          w_sclk_nxt    = 1'b0;
          w_sdata_nxt   = a_lamp[MX_LP-1];
          w_busy_nxt    = 1'b1;
        end
      end

      SHIFT: begin
        if (refresh) begin
          w_pending_nxt = 1'b1;
        end
        if (w_phase_done) begin
          if (!r_sclk) begin
            w_sclk_nxt = 1'b1;
          end else if (r_bit_cnt == BW'(MX_LP - 1)) begin
            w_state_nxt = LATCH;
            w_sclk_nxt  = 1'b0;
            w_sdata_nxt = 1'b0;
            w_latch_nxt = 1'b1;
          end else begin
            // Next bit is presented on the high->low edge of sclk.
            w_bit_cnt_nxt = r_bit_cnt + BW'(1);
            w_shreg_nxt   = w_shreg_shl;
            w_sdata_nxt   = w_shreg_shl[MX_LP-1];
            w_sclk_nxt    = 1'b0;
          end
        end
      end

      LATCH: begin
        if (refresh) begin
          w_pending_nxt = 1'b1;
        end
        if (w_phase_done) begin
          w_state_nxt     = IDLE;
          w_last_sent_nxt = r_frame;
          w_latch_nxt     = 1'b0;
          w_busy_nxt      = 1'b0;
        end
      end

      default: begin
        w_state_nxt = IDLE;
        w_sclk_nxt  = 1'b0;
        w_sdata_nxt = 1'b0;
        w_latch_nxt = 1'b0;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  assign sclk  = r_sclk;
  assign sdata = r_sdata;
  assign latch = r_latch;
  assign busy  = r_busy;

endmodule

// File: tb/tb_lamp_shifter.sv
// Bench for lamp_shifter: two instances (CLK_DIV=2 and CLK_DIV=1) share the
// stimulus; a timeline model predicts every output each cycle and a serial
// decoder reconstructs latched frames for the directed checks.
module tb_lamp_shifter;

  localparam int MX = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        refresh;
  logic [15:0] a_lamp;
  logic [1:0]  o_sclk, o_sdata, o_latch, o_busy;

  int checks   = 0;
  int failures = 0;
  int cyc_no   = 0;

  always #5 clk = ~clk;

  lamp_shifter #(.MX_LP(16), .CLK_DIV(2)) dut0 (
    .clk(clk), .rst(rst), .a_lamp(a_lamp), .refresh(refresh),
    .sclk(o_sclk[0]), .sdata(o_sdata[0]), .latch(o_latch[0]), .busy(o_busy[0])
  );

  lamp_shifter #(.MX_LP(16), .CLK_DIV(1)) dut1 (
    .clk(clk), .rst(rst), .a_lamp(a_lamp), .refresh(refresh),
    .sclk(o_sclk[1]), .sdata(o_sdata[1]), .latch(o_latch[1]), .busy(o_busy[1])
  );

  // Reference model: whether a frame is running and how far into it we are.
  bit          m_act [2];
  int          m_t   [2];
  logic [15:0] m_frame [2];
  logic [15:0] m_last  [2];
  bit          m_pend  [2];

  // Serial decoder / measurement state.
  logic        p_sclk [2], p_latch [2], p_busy [2];
  logic [15:0] bits [2], last_frame [2];
  int frames [2], busy_run [2], busy_len [2], busy_total [2];
  int latch_run [2], latch_len [2], last_rise [2], sclk_per [2];

  function automatic int cdv(input int i);
    return (i == 0) ? 2 : 1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_step(input int i, input logic [15:0] a, input logic rf, input logic r);
    int cd;
    cd = cdv(i);
    if (r) begin
      m_act[i] = 0; m_t[i] = 0; m_last[i] = '0; m_pend[i] = 0;
    end else if (!m_act[i]) begin
      if ((a != m_last[i]) || rf || m_pend[i]) begin
        m_act[i] = 1; m_t[i] = 0; m_frame[i] = a; m_pend[i] = 0;
      end
    end else begin
      if (rf) m_pend[i] = 1;
      m_t[i]++;
      if (m_t[i] == (2 * MX + 1) * cd) begin
        m_act[i] = 0;
        m_last[i] = m_frame[i];
      end
    end
  endtask

  function automatic logic [3:0] model_out(input int i);
    int cd;
    logic b, l, s, d;
    cd = cdv(i);
    b = 0; l = 0; s = 0; d = 0;
    if (m_act[i]) begin
      b = 1;
      if (m_t[i] < 2 * MX * cd) begin
        s = ((m_t[i] % (2 * cd)) >= cd);
        d = m_frame[i][MX - 1 - m_t[i] / (2 * cd)];
      end else begin
        l = 1;
      end
    end
    return {b, l, s, d};
  endfunction

  task automatic monitor(input int i);
    if (o_busy[i]) begin busy_run[i]++; busy_total[i]++; end
    if (p_busy[i] && !o_busy[i]) begin busy_len[i] = busy_run[i]; busy_run[i] = 0; end
    if (o_latch[i]) latch_run[i]++;
    if (p_latch[i] && !o_latch[i]) begin latch_len[i] = latch_run[i]; latch_run[i] = 0; end
    if (!p_latch[i] && o_latch[i]) begin frames[i]++; last_frame[i] = bits[i]; end
    if (!p_sclk[i] && o_sclk[i]) begin
      bits[i] = {bits[i][14:0], o_sdata[i]};
      sclk_per[i] = cyc_no - last_rise[i];
      last_rise[i] = cyc_no;
    end
    if (rst) begin busy_run[i] = 0; latch_run[i] = 0; end
    p_sclk[i] = o_sclk[i]; p_latch[i] = o_latch[i]; p_busy[i] = o_busy[i];
  endtask

  // One clock: drive inputs, advance the model at the edge, compare 1 time unit later.
  task automatic cyc(input logic [15:0] a, input logic rf, input logic r);
    a_lamp = a; refresh = rf; rst = r;
    @(posedge clk);
    cyc_no++;
    for (int i = 0; i < 2; i++) model_step(i, a, rf, r);
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("dut%0d_outputs_cyc%0d {busy,latch,sclk,sdata}", i, cyc_no),
            32'({o_busy[i], o_latch[i], o_sclk[i], o_sdata[i]}), 32'(model_out(i)));
      monitor(i);
    end
  endtask

  task automatic run(input logic [15:0] a, input int n);
    for (int k = 0; k < n; k++) cyc(a, 1'b0, 1'b0);
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] exp_frame;
    int          exp_busy [2];
    int          exp_latch [2];
    int          exp_per [2];
  } vec_t;

  vec_t vecs [5];
  int   f0 [2];

  initial begin
    vecs[0] = '{16'h8001, 16'h8001, '{66, 33}, '{2, 1}, '{4, 2}};
    vecs[1] = '{16'hA5A5, 16'hA5A5, '{66, 33}, '{2, 1}, '{4, 2}};
    vecs[2] = '{16'h00FF, 16'h00FF, '{66, 33}, '{2, 1}, '{4, 2}};
    vecs[3] = '{16'hFFFF, 16'hFFFF, '{66, 33}, '{2, 1}, '{4, 2}};
    vecs[4] = '{16'h0000, 16'h0000, '{66, 33}, '{2, 1}, '{4, 2}};

    for (int i = 0; i < 2; i++) begin
      m_act[i] = 0; m_t[i] = 0; m_frame[i] = '0; m_last[i] = '0; m_pend[i] = 0;
      p_sclk[i] = 0; p_latch[i] = 0; p_busy[i] = 0; bits[i] = '0; last_frame[i] = '0;
      frames[i] = 0; busy_run[i] = 0; busy_len[i] = 0; busy_total[i] = 0;
      latch_run[i] = 0; latch_len[i] = 0; last_rise[i] = 0; sclk_per[i] = 0;
    end
    a_lamp = '0; refresh = 1'b0; rst = 1'b1;

    // Reset held 3 cycles with a_lamp=0, then 100 quiet cycles.
    for (int k = 0; k < 3; k++) cyc(16'h0000, 1'b0, 1'b1);
    run(16'h0000, 100);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("dut%0d_quiet_busy_cycles", i), 32'(busy_total[i]), 32'd0);
      check($sformatf("dut%0d_quiet_frames", i), 32'(frames[i]), 32'd0);
    end

    // Single frames from IDLE: decoded bits, busy length, latch width, sclk period.
    foreach (vecs[v]) begin
      for (int i = 0; i < 2; i++) f0[i] = frames[i];
      run(vecs[v].a, 80);
      for (int i = 0; i < 2; i++) begin
        check($sformatf("dut%0d_vec%0d_frames", i, v), 32'(frames[i] - f0[i]), 32'd1);
        check($sformatf("dut%0d_vec%0d_bits", i, v), 32'(last_frame[i]), 32'(vecs[v].exp_frame));
        check($sformatf("dut%0d_vec%0d_busy_len", i, v), 32'(busy_len[i]), 32'(vecs[v].exp_busy[i]));
        check($sformatf("dut%0d_vec%0d_latch_len", i, v), 32'(latch_len[i]), 32'(vecs[v].exp_latch[i]));
        check($sformatf("dut%0d_vec%0d_sclk_period", i, v), 32'(sclk_per[i]), 32'(vecs[v].exp_per[i]));
      end
    end

    // Changes within a frame: 0001 -> 0003 -> 0007 gives two frames, last 0007.
    for (int i = 0; i < 2; i++) f0[i] = frames[i];
    run(16'h0001, 10);
    run(16'h0003, 10);
    run(16'h0007, 200);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("dut%0d_newest_wins_frames", i), 32'(frames[i] - f0[i]), 32'd2);
      check($sformatf("dut%0d_newest_wins_bits", i), 32'(last_frame[i]), 32'h0007);
    end

    // Refresh: one pulse in IDLE resends; three pulses while busy give one more frame.
    run(16'hFFFF, 80);
    for (int i = 0; i < 2; i++) f0[i] = frames[i];
    cyc(16'hFFFF, 1'b1, 1'b0);
    run(16'hFFFF, 79);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("dut%0d_refresh_idle_frames", i), 32'(frames[i] - f0[i]), 32'd1);
      check($sformatf("dut%0d_refresh_idle_bits", i), 32'(last_frame[i]), 32'hFFFF);
      f0[i] = frames[i];
    end
    cyc(16'hFFFF, 1'b1, 1'b0);
    for (int k = 1; k < 180; k++) cyc(16'hFFFF, (k == 5 || k == 15 || k == 25), 1'b0);
    for (int i = 0; i < 2; i++)
      check($sformatf("dut%0d_refresh_collapse_frames", i), 32'(frames[i] - f0[i]), 32'd2);

    // Reset during bit 8 of 0x00FF on dut0: no latch, then full retransmission.
    f0[0] = frames[0];
    run(16'h00FF, 34);
    cyc(16'h00FF, 1'b0, 1'b1);
    check("dut0_reset_midframe_no_latch", 32'(frames[0] - f0[0]), 32'd0);
    check("dut0_reset_outputs", 32'({o_busy[0], o_latch[0], o_sclk[0], o_sdata[0]}), 32'd0);
    run(16'h00FF, 100);
    check("dut0_after_reset_frames", 32'(frames[0] - f0[0]), 32'd1);
    for (int i = 0; i < 2; i++)
      check($sformatf("dut%0d_after_reset_bits", i), 32'(last_frame[i]), 32'h00FF);

    // Randomised traffic checked cycle by cycle against the model.
    begin
      logic [15:0] ra;
      ra = 16'h1234;
      for (int k = 0; k < 3000; k++) begin
        if ($urandom_range(0, 49) == 0) ra = 16'($urandom);
        cyc(ra, ($urandom_range(0, 39) == 0), ($urandom_range(0, 499) == 0));
      end
      run(ra, 150);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
